coprosit_issue_ctrl: RTL and testbench

Parametrised issue and scoreboard controller for the coprosit coprocessor. It sits between the input buffer head and the execution, memory and result paths. It dispatches each committed instruction to a pipelined execution unit (up to `MAX_INFLIGHT` in flight) or to the memory interface, and drops killed instructions. It tracks posit register hazards with forwarding, and arbitrates the single posit register-file write port between execution results and load responses.

---
 rtl/coprosit_issue_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_coprosit_issue_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coprosit_issue_ctrl.sv
// coprosit_issue_ctrl
// Issue and scoreboard controller for the coprosit coprocessor. Takes the
// instruction at the input-buffer head and either dispatches it to the
// pipelined execution unit or to the memory interface, or discards it when it
// has been killed. A per-register scoreboard tracks outstanding posit writes.
// Optional bypass paths let a dependent instruction issue in the same cycle
// its operand is written back. The single register-file write port is shared
// by load responses (priority) and execution results.
//
// Ports
//   clk_i, rst_ni                  clock, async active-low reset
//   in_buf_pop_*, id_i, rs_i,      input-buffer head and its decoded fields
//   rs_used_i, rd_i, rd_is_pos_i,
//   is_load_i, is_store_i
//   commit_*                       commit / kill notification per id
//   ex_in_*                        execution-unit issue handshake
//   ex_out_*                       execution-unit result handshake
//   mem_req_*, mem_rsp_*           memory request / load response
//   posr_we_o, posr_waddr_o        posit register-file write port
//   fwd_sel_o                      per operand: 0 regfile, 1 ex bypass, 2 mem bypass
//   result_hs_i, result_id_i       result transaction finished for an id
//   drop_o                         killed head discarded this cycle
//   inflight_o                     instructions inside the execution unit
//
// Handshakes: a transfer happens in a cycle where valid and ready are both
// high. A valid output is never a function of its own ready input; ready
// outputs may look at the matching valid.
module coprosit_issue_ctrl #(
  parameter int unsigned NUM_RS       = 2,
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned ID_WIDTH     = 4,
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned FORWARDING   = 1,
  localparam int unsigned RW = $clog2(NUM_REGS),
  localparam int unsigned CW = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_buf_pop_valid_i,
  output logic                   in_buf_pop_ready_o,
  input  logic [ID_WIDTH-1:0]    id_i,
  input  logic [NUM_RS*RW-1:0]   rs_i,
  input  logic [NUM_RS-1:0]      rs_used_i,
  input  logic [RW-1:0]          rd_i,
  input  logic                   rd_is_pos_i,
  input  logic                   is_load_i,
  input  logic                   is_store_i,
  input  logic                   commit_valid_i,
  input  logic [ID_WIDTH-1:0]    commit_id_i,
  input  logic                   commit_kill_i,
  output logic                   ex_in_valid_o,
  input  logic                   ex_in_ready_i,
  input  logic                   ex_out_valid_i,
  output logic                   ex_out_ready_o,
  input  logic [RW-1:0]          ex_out_rd_i,
  input  logic                   ex_out_we_i,
  output logic                   mem_req_valid_o,
  input  logic                   mem_req_ready_i,
  output logic                   mem_req_we_o,
  input  logic                   mem_rsp_valid_i,
  input  logic [RW-1:0]          mem_rsp_rd_i,
  input  logic                   mem_rsp_we_i,
  output logic                   posr_we_o,
  output logic [RW-1:0]          posr_waddr_o,
  output logic [NUM_RS*2-1:0]    fwd_sel_o,
  input  logic                   result_hs_i,
  input  logic [ID_WIDTH-1:0]    result_id_i,
  output logic                   drop_o,
  output logic [CW-1:0]          inflight_o
);

  localparam int unsigned NIDS = 2 ** ID_WIDTH;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_INFLIGHT);

  logic [NUM_REGS-1:0]         rd_sb_q, rd_sb_d;
  logic [NIDS-1:0]             cmt_q, cmt_d;
  logic [NIDS-1:0]             kill_q, kill_d, kill_nxt;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [NUM_RS-1:0][RW-1:0]   rs;
  logic [NUM_RS-1:0][1:0]      fwd_sel;
  logic ex_out_hs, ex_in_hs, mem_req_hs;
  logic mem_wr, ex_wr;
  logic head_killed, head_ok, is_mem;
  logic dep_rs, dep_rd, sb_set;

  assign rs = rs_i;

  // Commit/result bookkeeping; the *_d values are what the head sees this
  // cycle, so a commit arriving with the head lets it issue immediately.
  // A result clear wins over a same-cycle commit of the same id.
  always_comb begin
    cmt_d  = cmt_q;
    kill_d = kill_q;
    if (commit_valid_i) begin
      if (commit_kill_i) kill_d[commit_id_i] = 1'b1;
      else               cmt_d[commit_id_i]  = 1'b1;
    end
    if (result_hs_i) cmt_d[result_id_i] = 1'b0;
  end

  // Writeback arbitration: a load response always takes the port, so the
  // execution unit is back-pressured whenever one is present.
  assign ex_out_ready_o = ~mem_rsp_valid_i;
  assign ex_out_hs      = ex_out_valid_i & ex_out_ready_o;
  assign mem_wr         = mem_rsp_valid_i & mem_rsp_we_i;
  assign ex_wr          = ex_out_hs & ex_out_we_i;
  assign posr_we_o      = mem_wr | ex_wr;
  assign posr_waddr_o   = mem_wr ? mem_rsp_rd_i : ex_out_rd_i;

  // Operand bypass selection and read-after-write hazard detection. An
  // operand whose pending write is being bypassed no longer blocks issue.
  always_comb begin
    fwd_sel = '0;
    dep_rs  = 1'b0;
    for (int k = 0; k < NUM_RS; k++) begin
      if (rs_used_i[k]) begin
        if (FORWARDING != 0) begin
          if (ex_wr && (rs[k] == ex_out_rd_i))        fwd_sel[k] = 2'd1;
          else if (mem_wr && (rs[k] == mem_rsp_rd_i)) fwd_sel[k] = 2'd2;
        end
        if (rd_sb_q[rs[k]] && (fwd_sel[k] == 2'd0)) dep_rs = 1'b1;
      end
    end
  end

  assign fwd_sel_o = fwd_sel;

  // WAW: a pending write to the same destination stalls, unless it retires
  // this very cycle (the new writer then re-arms the scoreboard bit).
  assign dep_rd = rd_is_pos_i & rd_sb_q[rd_i] &
                  ~(posr_we_o & (posr_waddr_o == rd_i));

  assign head_killed = in_buf_pop_valid_i & kill_d[id_i];
  assign head_ok     = in_buf_pop_valid_i & ~kill_d[id_i] & cmt_d[id_i] &
                       ~dep_rs & ~dep_rd;
  assign is_mem      = is_load_i | is_store_i;

  // A full execution pipe still accepts when one result leaves this cycle.
  assign ex_in_valid_o   = head_ok & ~is_mem & ((cnt_q < MAX_CNT) | ex_out_hs);
  assign mem_req_valid_o = head_ok & is_mem;
  assign mem_req_we_o    = is_store_i;
  assign ex_in_hs        = ex_in_valid_o & ex_in_ready_i;
  assign mem_req_hs      = mem_req_valid_o & mem_req_ready_i;

  assign in_buf_pop_ready_o = head_killed | ex_in_hs | mem_req_hs;
  assign drop_o             = head_killed;
  assign inflight_o         = cnt_q;

  always_comb begin
    kill_nxt = kill_d;
    if (head_killed) kill_nxt[id_i] = 1'b0;
  end

  // Scoreboard: clear on writeback first, then set, so a same-cycle set of
  // the same register is kept.
  assign sb_set = (ex_in_hs & rd_is_pos_i) | (mem_req_hs & is_load_i);

  always_comb begin
    rd_sb_d = rd_sb_q;
    if (posr_we_o) rd_sb_d[posr_waddr_o] = 1'b0;
    if (sb_set)    rd_sb_d[rd_i]         = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({ex_in_hs, ex_out_hs})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_sb_q <= '0;
      cmt_q   <= '0;
      kill_q  <= '0;
      cnt_q   <= '0;
    end else begin
      rd_sb_q <= rd_sb_d;
      cmt_q   <= cmt_d;
      kill_q  <= kill_nxt;
      cnt_q   <= cnt_d;
    end
  end

  // A result from an empty execution unit is an upstream protocol error.
  a_no_result_when_empty: assert property (
    @(posedge clk_i) disable iff (!rst_ni) ex_out_valid_i |-> (cnt_q != '0));

endmodule

// File: tb/tb_coprosit_issue_ctrl.sv
module tb_coprosit_issue_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pop_valid;
    logic [3:0] id;
    logic [9:0] rs;
    logic [1:0] rs_used;
    logic [4:0] rd;
    logic       rd_is_pos;
    logic       is_load;
    logic       is_store;
    logic       commit_valid;
    logic [3:0] commit_id;
    logic       commit_kill;
    logic       ex_in_ready;
    logic       ex_out_valid;
    logic [4:0] ex_out_rd;
    logic       ex_out_we;
    logic       mem_req_ready;
    logic       mem_rsp_valid;
    logic [4:0] mem_rsp_rd;
    logic       mem_rsp_we;
    logic       result_hs;
    logic [3:0] result_id;
  } in_t;

  localparam in_t IDLE = '0;

  in_t  din;
  logic sel;   // 0: forwarding DUT driven, 1: non-forwarding DUT driven
  in_t  ia, ib;
  assign ia = sel ? IDLE : din;
  assign ib = sel ? din : IDLE;

  logic       pop_a, exv_a, exr_a, memv_a, memwe_a, we_a, drop_a;
  logic [4:0] wa_a;
  logic [3:0] fwd_a;
  logic [2:0] infl_a;
  logic       pop_b, exv_b, exr_b, memv_b, memwe_b, we_b, drop_b;
  logic [4:0] wa_b;
  logic [3:0] fwd_b;
  logic [2:0] infl_b;

  coprosit_issue_ctrl #(.FORWARDING(1)) u_fwd (
    .clk_i(clk), .rst_ni(rst_n),
    .in_buf_pop_valid_i(ia.pop_valid), .in_buf_pop_ready_o(pop_a),
    .id_i(ia.id), .rs_i(ia.rs), .rs_used_i(ia.rs_used), .rd_i(ia.rd),
    .rd_is_pos_i(ia.rd_is_pos), .is_load_i(ia.is_load), .is_store_i(ia.is_store),
    .commit_valid_i(ia.commit_valid), .commit_id_i(ia.commit_id), .commit_kill_i(ia.commit_kill),
    .ex_in_valid_o(exv_a), .ex_in_ready_i(ia.ex_in_ready),
    .ex_out_valid_i(ia.ex_out_valid), .ex_out_ready_o(exr_a),
    .ex_out_rd_i(ia.ex_out_rd), .ex_out_we_i(ia.ex_out_we),
    .mem_req_valid_o(memv_a), .mem_req_ready_i(ia.mem_req_ready), .mem_req_we_o(memwe_a),
    .mem_rsp_valid_i(ia.mem_rsp_valid), .mem_rsp_rd_i(ia.mem_rsp_rd), .mem_rsp_we_i(ia.mem_rsp_we),
    .posr_we_o(we_a), .posr_waddr_o(wa_a), .fwd_sel_o(fwd_a),
    .result_hs_i(ia.result_hs), .result_id_i(ia.result_id),
    .drop_o(drop_a), .inflight_o(infl_a)
  );

  coprosit_issue_ctrl #(.FORWARDING(0)) u_nofwd (
    .clk_i(clk), .rst_ni(rst_n),
    .in_buf_pop_valid_i(ib.pop_valid), .in_buf_pop_ready_o(pop_b),
    .id_i(ib.id), .rs_i(ib.rs), .rs_used_i(ib.rs_used), .rd_i(ib.rd),
    .rd_is_pos_i(ib.rd_is_pos), .is_load_i(ib.is_load), .is_store_i(ib.is_store),
    .commit_valid_i(ib.commit_valid), .commit_id_i(ib.commit_id), .commit_kill_i(ib.commit_kill),
    .ex_in_valid_o(exv_b), .ex_in_ready_i(ib.ex_in_ready),
    .ex_out_valid_i(ib.ex_out_valid), .ex_out_ready_o(exr_b),
    .ex_out_rd_i(ib.ex_out_rd), .ex_out_we_i(ib.ex_out_we),
    .mem_req_valid_o(memv_b), .mem_req_ready_i(ib.mem_req_ready), .mem_req_we_o(memwe_b),
    .mem_rsp_valid_i(ib.mem_rsp_valid), .mem_rsp_rd_i(ib.mem_rsp_rd), .mem_rsp_we_i(ib.mem_rsp_we),
    .posr_we_o(we_b), .posr_waddr_o(wa_b), .fwd_sel_o(fwd_b),
    .result_hs_i(ib.result_hs), .result_id_i(ib.result_id),
    .drop_o(drop_b), .inflight_o(infl_b)
  );

  // Observed output vector: pop,exv,memv,memwe,exrdy,we,waddr[4:0],fwd[3:0],drop,infl[2:0]
  localparam int W = 19;
  logic [W-1:0] obs_a, obs_b;
  assign obs_a = {pop_a, exv_a, memv_a, memwe_a, exr_a, we_a, wa_a, fwd_a, drop_a, infl_a};
  assign obs_b = {pop_b, exv_b, memv_b, memwe_b, exr_b, we_b, wa_b, fwd_b, drop_b, infl_b};

  function automatic logic [W-1:0] mk(input logic pop, input logic exv, input logic memv,
                                      input logic memwe, input logic exrdy, input logic we,
                                      input logic [4:0] wa, input logic [3:0] fwd,
                                      input logic drop, input logic [2:0] infl);
    return {pop, exv, memv, memwe, exrdy, we, wa, fwd, drop, infl};
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           total = 0;
  int           passed = 0;

  // Monitor: one expected vector per checked cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e, a;
      string        n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = sel ? obs_b : obs_a;
      if (!e[13]) begin   // write address is meaningless without a write
        e[12:8] = '0;
        a[12:8] = '0;
      end
      total++;
      if (a !== e)
        $display("FAIL %s: got pop=%b exv=%b memv=%b memwe=%b exrdy=%b we=%b wa=%0d fwd=%b drop=%b infl=%0d, expected pop=%b exv=%b memv=%b memwe=%b exrdy=%b we=%b wa=%0d fwd=%b drop=%b infl=%0d",
                 n, a[18], a[17], a[16], a[15], a[14], a[13], a[12:8], a[7:4], a[3], a[2:0],
                 e[18], e[17], e[16], e[15], e[14], e[13], e[12:8], e[7:4], e[3], e[2:0]);
      else
        passed++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic head(input logic [3:0] id, input logic [4:0] rs0, input logic [4:0] rs1,
                      input logic [1:0] used, input logic [4:0] rd, input logic rdpos,
                      input logic ld, input logic st);
    din.pop_valid = 1'b1;
    din.id        = id;
    din.rs        = {rs1, rs0};
    din.rs_used   = used;
    din.rd        = rd;
    din.rd_is_pos = rdpos;
    din.is_load   = ld;
    din.is_store  = st;
  endtask

  task automatic no_head();
    din.pop_valid = 1'b0;
    din.id        = '0;
    din.rs        = '0;
    din.rs_used   = '0;
    din.rd        = '0;
    din.rd_is_pos = 1'b0;
    din.is_load   = 1'b0;
    din.is_store  = 1'b0;
  endtask

  task automatic commit(input logic [3:0] id, input logic kill);
    din.commit_valid = 1'b1;
    din.commit_id    = id;
    din.commit_kill  = kill;
  endtask

  task automatic result(input logic [3:0] id);
    din.result_hs = 1'b1;
    din.result_id = id;
  endtask

  task automatic ex_out(input logic [4:0] rd);
    din.ex_out_valid = 1'b1;
    din.ex_out_rd    = rd;
    din.ex_out_we    = 1'b1;
  endtask

  task automatic mem_rsp(input logic [4:0] rd);
    din.mem_rsp_valid = 1'b1;
    din.mem_rsp_rd    = rd;
    din.mem_rsp_we    = 1'b1;
  endtask

  // Queue the expectation for the current cycle, advance one cycle, then
  // retire the single-cycle pulses.
  task automatic chk(input string name, input logic [W-1:0] e);
    exp_q.push_back(e);
    name_q.push_back(name);
    @(posedge clk);
    #1;
    din.commit_valid  = 1'b0;
    din.commit_kill   = 1'b0;
    din.result_hs     = 1'b0;
    din.ex_out_valid  = 1'b0;
    din.ex_out_we     = 1'b0;
    din.mem_rsp_valid = 1'b0;
    din.mem_rsp_we    = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    sel = 1'b0;
    din = IDLE;
    din.ex_in_ready   = 1'b1;
    din.mem_req_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    chk("reset_fwd", mk(0,0,0,0,1,0,0,0,0,0));
    sel = 1'b1;
    chk("reset_nofwd", mk(0,0,0,0,1,0,0,0,0,0));
    sel = 1'b0;

    // Commit bypass
    head(3, 1, 2, 2'b11, 10, 1, 0, 0);
    chk("uncommitted", mk(0,0,0,0,1,0,0,0,0,0));
    commit(3, 0);
    chk("commit_bypass", mk(1,1,0,0,1,0,0,0,0,0));
    no_head(); result(3); ex_out(10);
    chk("drain_r10", mk(0,0,0,0,1,1,10,0,0,1));

    // Fill the execution unit
    for (int i = 0; i < 4; i++) begin
      head(4'(4 + i), 1, 2, 2'b11, 5'(11 + i), 1, 0, 0);
      commit(4'(4 + i), 0);
      chk($sformatf("fill_%0d", i), mk(1,1,0,0,1,0,0,0,0,3'(i)));
    end
    head(8, 1, 2, 2'b11, 15, 1, 0, 0); commit(8, 0);
    chk("full_stall", mk(0,0,0,0,1,0,0,0,0,4));
    ex_out(11);
    chk("full_issue", mk(1,1,0,0,1,1,11,0,0,4));
    no_head();
    chk("held_at_max", mk(0,0,0,0,1,0,0,0,0,4));
    for (int i = 0; i < 3; i++) begin
      ex_out(5'(12 + i));
      chk($sformatf("drain_%0d", i), mk(0,0,0,0,1,1,5'(12 + i),0,0,3'(4 - i)));
    end

    // RAW on r5 resolved by execution bypass
    head(1, 1, 2, 2'b11, 5, 1, 0, 0); commit(1, 0);
    chk("writer_r5", mk(1,1,0,0,1,0,0,0,0,1));
    head(2, 5, 3, 2'b11, 5, 1, 0, 0); commit(2, 0);
    chk("raw_stall", mk(0,0,0,0,1,0,0,0,0,2));
    ex_out(5);
    chk("raw_ex_fwd", mk(1,1,0,0,1,1,5,4'b0001,0,2));
    head(4, 5, 0, 2'b01, 20, 1, 0, 0);
    chk("sb_r5_kept", mk(0,0,0,0,1,0,0,0,0,2));
    mem_rsp(5);
    chk("raw_mem_fwd", mk(1,1,0,0,0,1,5,4'b0010,0,2));

    // Load and writeback priority
    head(6, 0, 0, 2'b00, 7, 1, 1, 0);
    chk("load_issue", mk(1,0,1,0,1,0,0,0,0,3));
    no_head(); mem_rsp(7); ex_out(15);
    chk("mem_priority", mk(0,0,0,0,0,1,7,0,0,3));
    ex_out(15);
    chk("ex_after_mem", mk(0,0,0,0,1,1,15,0,0,3));
    head(7, 3, 0, 2'b01, 0, 0, 0, 1);
    chk("store_issue", mk(1,0,1,1,1,0,0,0,0,2));

    // Kill / drop
    head(9, 1, 0, 2'b01, 3, 1, 0, 0); commit(9, 1);
    chk("kill_drop", mk(1,0,0,0,1,0,0,0,1,2));
    chk("kill_cleared", mk(0,0,0,0,1,0,0,0,0,2));
    head(5, 3, 0, 2'b01, 21, 1, 0, 0);
    chk("sb_untouched_by_drop", mk(1,1,0,0,1,0,0,0,0,2));

    // Result clear beats same-cycle commit
    head(10, 0, 0, 2'b00, 22, 1, 0, 0); commit(10, 0); result(10);
    chk("result_wins", mk(0,0,0,0,1,0,0,0,0,3));
    chk("result_wins_held", mk(0,0,0,0,1,0,0,0,0,3));
    no_head();

    // Same RAW case without bypass: one extra stall cycle
    sel = 1'b1;
    head(1, 1, 2, 2'b11, 5, 1, 0, 0); commit(1, 0);
    chk("nf_writer_r5", mk(1,1,0,0,1,0,0,0,0,0));
    head(2, 5, 3, 2'b11, 6, 1, 0, 0); commit(2, 0);
    chk("nf_raw_stall", mk(0,0,0,0,1,0,0,0,0,1));
    ex_out(5);
    chk("nf_wb_still_stall", mk(0,0,0,0,1,1,5,0,0,1));
    chk("nf_issue", mk(1,1,0,0,1,0,0,0,0,0));
    no_head();

    @(posedge clk);
    #1;
    total++;
    if (exp_q.size() != 0)
      $display("FAIL queue_drained: got %0d pending, expected 0", exp_q.size());
    else
      passed++;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
